// File: rtl/tmds_pkg.sv
// Shared constants, types and width helpers for the TMDS lane decoder.
package tmds_pkg;

  // Control tokens as q[9:0], MSB first, named by {c1,c0}
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // TERC4 code table; entry i encodes nibble i
  localparam logic [9:0] TERC4_TABLE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } tmds_state_t;

  // Bits needed for a counter holding values 0..n-1
  function automatic int timer_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned TMDS symbol into its video, control
// and TERC4 interpretations. All three are produced every cycle; the
// consumer decides which one applies.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl,
  output logic [3:0] terc4,
  output logic       is_terc4
);

  logic [7:0] d;

  // Video: undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Control token match
  always_comb begin
    ctrl    = 2'd0;
    is_ctrl = 1'b0;
    case (sym)
      CTRL_TOKEN_00: begin ctrl = 2'd0; is_ctrl = 1'b1; end
      CTRL_TOKEN_01: begin ctrl = 2'd1; is_ctrl = 1'b1; end
      CTRL_TOKEN_10: begin ctrl = 2'd2; is_ctrl = 1'b1; end
      CTRL_TOKEN_11: begin ctrl = 2'd3; is_ctrl = 1'b1; end
      default: ;
    endcase
  end

  // TERC4 table search
  always_comb begin
    terc4    = 4'd0;
    is_terc4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sym == TERC4_TABLE[i]) begin
        terc4    = 4'(i);
        is_terc4 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: word alignment by control-token runs, then
// per-symbol decode into video / control / TERC4 fields.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SEARCH | trying the current bit_offset, waiting for a control run
// ST_SLIP   | one-cycle flush after bit_offset advanced
// ST_LOCKED | aligned; runs of control tokens keep the loss timer cleared
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 2097152
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       realign,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       is_ctrl,
  output logic [3:0] terc4_out,
  output logic       is_terc4,
  output logic       locked,
  output logic [3:0] bit_offset
);

  // run_cnt saturates at CTRL_RUN itself, so it needs one more code
  localparam int RUN_W  = timer_width(CTRL_RUN + 1);
  localparam int TMO_W  = timer_width(SEARCH_TIMEOUT);
  localparam int LOSS_W = timer_width(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(CTRL_RUN);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  logic [9:0]  prev_q;
  logic [9:0]  aligned_q;
  logic [18:0] pair;
  logic [9:0]  window;

  logic [7:0]  dec_data;
  logic [1:0]  dec_ctrl;
  logic        dec_is_ctrl;
  logic [3:0]  dec_terc4;
  logic        dec_is_terc4;

  tmds_state_t       state_q, state_d;
  logic [3:0]        offset_d, offset_adv;
  logic [RUN_W-1:0]  run_cnt, run_d, run_inc;
  logic [TMO_W-1:0]  tmo_cnt, tmo_d;
  logic [LOSS_W-1:0] loss_cnt, loss_d;
  logic              run_hit;

  // Only bits 0..18 of {data_in, prev_q} can ever fall in the window
  assign pair = {data_in[8:0], prev_q};

  // Barrel-select the 10-bit window at the current offset
  always_comb begin
    window = prev_q;
    for (int k = 0; k < 10; k++) begin
      if (bit_offset == 4'(k)) window = pair[k +: 10];
    end
  end

  tmds_symbol_decode u_decode (
    .sym      (aligned_q),
    .data     (dec_data),
    .ctrl     (dec_ctrl),
    .is_ctrl  (dec_is_ctrl),
    .terc4    (dec_terc4),
    .is_terc4 (dec_is_terc4)
  );

  // Input history, aligned symbol and decoded output registers
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      prev_q    <= '0;
      aligned_q <= '0;
      data_out  <= '0;
      ctrl_out  <= '0;
      is_ctrl   <= 1'b0;
      terc4_out <= '0;
      is_terc4  <= 1'b0;
    end else begin
      prev_q    <= data_in;
      aligned_q <= window;
      data_out  <= dec_data;
      ctrl_out  <= dec_ctrl;
      is_ctrl   <= dec_is_ctrl;
      terc4_out <= dec_terc4;
      is_terc4  <= dec_is_terc4;
    end
  end

  // Run length including the symbol being registered this cycle, so lock
  // lands on the same edge as the qualifying is_ctrl
  always_comb begin
    if (!dec_is_ctrl)           run_inc = '0;
    else if (run_cnt == RUN_FULL) run_inc = RUN_FULL;
    else                        run_inc = run_cnt + RUN_W'(1);
  end

  assign run_hit    = (run_inc == RUN_FULL);
  assign offset_adv = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;

  // Next-state and counter updates; realign overrides every other outcome
  always_comb begin
    state_d  = state_q;
    offset_d = bit_offset;
    run_d    = run_inc;
    tmo_d    = '0;
    loss_d   = '0;
    case (state_q)
      ST_SEARCH: begin
        tmo_d = tmo_cnt + TMO_W'(1);
        if (run_hit) begin
          state_d = ST_LOCKED;
          tmo_d   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d  = ST_SLIP;
          offset_d = offset_adv;
          run_d    = '0;
          tmo_d    = '0;
        end
      end
      ST_SLIP: begin
        // Window still holds a word from the old offset; ignore it
        run_d   = '0;
        state_d = ST_SEARCH;
      end
      ST_LOCKED: begin
        loss_d = loss_cnt + LOSS_W'(1);
        if (run_hit) begin
          loss_d = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_d = ST_SEARCH;
          loss_d  = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        run_d   = '0;
      end
    endcase
    if (realign) begin
      state_d  = ST_SLIP;
      offset_d = offset_adv;
      run_d    = '0;
      tmo_d    = '0;
      loss_d   = '0;
    end
  end

  // FSM state, offset and counter registers
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      bit_offset <= '0;
      run_cnt    <= '0;
      tmo_cnt    <= '0;
      loss_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      bit_offset <= offset_d;
      run_cnt    <= run_d;
      tmo_cnt    <= tmo_d;
      loss_cnt   <= loss_d;
    end
  end

  assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, lock, decode, loss of
// lock, realign corner cases and offset search on a rotated stream.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] VID0 = 10'b0100000000;
  localparam int LINE       = 1650;
  localparam int CTRL_WORDS = 370;
  localparam int ROT_BUDGET = 4 * 2049 + 1650;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] data_in;
  logic       realign;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       is_ctrl;
  logic [3:0] terc4_out;
  logic       is_terc4;
  logic       locked;
  logic [3:0] bit_offset;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] w;
    logic [7:0] d;
    logic       c;
    logic [1:0] cc;
    logic       t;
    logic [3:0] tn;
  } dvec_t;

  dvec_t      dv [6];
  logic [9:0] tok;
  logic [9:0] w9;
  logic [3:0] last_off;
  bit         got_lock;
  int         n;
  int         offs [$];

  tmds_channel_decoder #(
    .CTRL_RUN       (8),
    .SEARCH_TIMEOUT (2048),
    .LOSS_TIMEOUT   (256)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .data_in    (data_in),
    .realign    (realign),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .is_ctrl    (is_ctrl),
    .terc4_out  (terc4_out),
    .is_terc4   (is_terc4),
    .locked     (locked),
    .bit_offset (bit_offset)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one word, let one edge pass, return 1 time unit after it
  task automatic step(input logic [9:0] w, input logic rl);
    data_in = w;
    realign = rl;
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic logic [9:0] sym_at(input int m);
    return ((m % LINE) < CTRL_WORDS) ? T00 : VID0;
  endfunction

  // Deserializer word that starts 3 serial bits before a symbol boundary
  function automatic logic [9:0] rot_word(input int m);
    logic [9:0] a;
    logic [9:0] b;
    a = sym_at(m);
    b = sym_at(m + 1);
    return {b[6:0], a[9:7]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0] = '{10'b0100000000, 8'h00, 1'b0, 2'd0, 1'b0, 4'h0};
    dv[1] = '{10'b1011111111, 8'hFE, 1'b0, 2'd0, 1'b0, 4'h0};
    dv[2] = '{10'b1010011100, 8'h5B, 1'b0, 2'd0, 1'b1, 4'h0};
    dv[3] = '{10'b1011000011, 8'hBA, 1'b0, 2'd0, 1'b1, 4'hF};
    dv[4] = '{T11,            8'h02, 1'b1, 2'd3, 1'b0, 4'h0};
    dv[5] = '{T01,            8'h03, 1'b1, 2'd1, 1'b0, 4'h0};

    // Reset with random data
    reset   = 1'b1;
    realign = 1'b0;
    data_in = '0;
    for (int i = 0; i < 4; i++) step(10'($urandom), 1'b0);
    chk("rst_data_out",  data_out,   0);
    chk("rst_ctrl_out",  ctrl_out,   0);
    chk("rst_is_ctrl",   is_ctrl,    0);
    chk("rst_terc4_out", terc4_out,  0);
    chk("rst_is_terc4",  is_terc4,   0);
    chk("rst_locked",    locked,     0);
    chk("rst_offset",    bit_offset, 0);

    // 20 aligned control tokens: token k shows after edge k+2, lock at token 8
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(T00, 1'b0);
      chk("run_is_ctrl", is_ctrl, (i >= 3));
      chk("run_locked",  locked,  (i >= 10));
      if (i >= 3) chk("run_ctrl_code", ctrl_out, 0);
    end
    chk("run_offset", bit_offset, 0);

    // Decode of individual symbols while locked
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) step(dv[k].w, 1'b0);
      chk("dec_data",     data_out, dv[k].d);
      chk("dec_is_ctrl",  is_ctrl,  dv[k].c);
      chk("dec_is_terc4", is_terc4, dv[k].t);
      if (dv[k].c) chk("dec_ctrl_code", ctrl_out,  dv[k].cc);
      if (dv[k].t) chk("dec_terc4_val", terc4_out, dv[k].tn);
    end
    chk("dec_still_locked", locked, 1);

    // Loss of lock: exactly 8 tokens then video; lock at edge 10, drop at 266
    reset = 1'b1;
    step(VID0, 1'b0);
    step(VID0, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 308; i++) begin
      step((i <= 8) ? T00 : VID0, 1'b0);
      chk("loss_locked", locked, (i >= 10 && i < 266));
    end
    chk("loss_offset", bit_offset, 0);

    // Realign from offset 9 while locked wraps to 0 and drops lock
    reset = 1'b1;
    step(VID0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(VID0, 1'b1);
      step(VID0, 1'b0);
    end
    chk("wrap_offset9", bit_offset, 9);
    tok = T00;
    w9  = {tok[0], tok[9:1]};
    for (int i = 0; i < 14; i++) step(w9, 1'b0);
    chk("wrap_locked_at9", locked, 1);
    step(w9, 1'b1);
    chk("wrap_offset0", bit_offset, 0);
    chk("wrap_unlocked", locked, 0);

    // Realign on the cycle the 8th token would lock
    reset = 1'b1;
    step(VID0, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(T00, (i == 10));
      if (i == 10) begin
        chk("race_locked", locked, 0);
        chk("race_offset", bit_offset, 1);
      end
    end
    chk("race_locked_after", locked, 0);
    chk("race_offset_after", bit_offset, 1);

    // Reset while in SLIP
    reset = 1'b1;
    step(VID0, 1'b0);
    reset = 1'b0;
    step(VID0, 1'b1);
    step(VID0, 1'b1);
    step(VID0, 1'b1);
    chk("slip_offset3", bit_offset, 3);
    reset = 1'b1;
    step(VID0, 1'b0);
    chk("slip_rst_offset", bit_offset, 0);
    chk("slip_rst_locked", locked, 0);
    reset = 1'b0;

    // Stream rotated by 3 bits: search must walk 0,1,2,3 and lock
    reset = 1'b1;
    step(VID0, 1'b0);
    step(VID0, 1'b0);
    reset = 1'b0;
    last_off = bit_offset;
    got_lock = 1'b0;
    n = 0;
    while (!got_lock && n < ROT_BUDGET) begin
      step(rot_word(n), 1'b0);
      n++;
      if (bit_offset != last_off) begin
        offs.push_back(int'(bit_offset));
        last_off = bit_offset;
      end
      if (locked) got_lock = 1'b1;
    end
    chk("rot_lock_in_budget", got_lock, 1);
    chk("rot_offset", bit_offset, 3);
    chk("rot_step_count", offs.size(), 3);
    for (int k = 0; k < offs.size(); k++) chk("rot_step_value", offs[k], k + 1);
    for (int i = 0; i < 200; i++) begin
      step(rot_word(n), 1'b0);
      n++;
    end
    chk("rot_offset_hold", bit_offset, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
